// File: rtl/input_debouncer.sv
// input_debouncer: synchronises one raw asynchronous input into the clk domain and
// only lets the output level change after DEBOUNCE_CYCLES consecutive identical
// synchronised samples. Also produces one-cycle rise/fall strobes and a busy flag
// that is high while a candidate transition is being qualified.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_in;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the raw input through the synchroniser chain, newest sample at bit 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Synchroniser flops; cleared while in reset so a stale level cannot leak out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // State register: FSM state, stability counter and the registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOW;
      cnt_q   <= CNT_ZERO;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: any opposite sample during a wait drops the candidate and the
  // count restarts from zero, so the counter saturates at DEBOUNCE_CYCLES-1 at most.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync_in) begin
          state_d = S_RISE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      S_RISE_WAIT: begin
        if (!sync_in) begin
          state_d = S_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = CNT_ZERO;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          state_d = S_FALL_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      S_FALL_WAIT: begin
        if (sync_in) begin
          state_d = S_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = CNT_ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decode purely from registered state, so raw_in has no combinational path out.
  always_comb begin
    level_out  = (state_q == S_HIGH) || (state_q == S_FALL_WAIT);
    busy       = (state_q == S_RISE_WAIT) || (state_q == S_FALL_WAIT);
    rise_pulse = rise_q;
    fall_pulse = fall_q;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default instance checked every cycle against a
// sliding-window scoreboard plus a segment table; a second instance with
// SYNC_STAGES=3, DEBOUNCE_CYCLES=2 checked by hand-written sequences.
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic raw_in = 1'b0;
  logic raw2   = 1'b0;
  logic level_out, rise_pulse, fall_pulse, busy;
  logic level2, rise2, fall2, busy2;

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
  );

  input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .raw_in(raw2),
    .level_out(level2), .rise_pulse(rise2), .fall_pulse(fall2), .busy(busy2)
  );

  // Expected {level, rise, fall, busy} tagged with the edge it belongs to.
  typedef struct {
    int         e;
    logic [3:0] v;
  } exp_t;

  typedef struct {
    logic val;
    int   len;
    int   er;
    int   ef;
    logic el;
  } seg_t;

  exp_t sb[$];
  logic win[$];
  logic m_level;
  int   edge_num;
  int   n_total = 0;
  int   n_pass  = 0;
  int   rise_cnt, fall_cnt;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: level flips only when the last DEB synchronised samples all agree.
  task automatic model_reset();
    exp_t x;
    sb.delete();
    win.delete();
    for (int i = 0; i < DEB; i++) win.push_back(1'b0);
    m_level  = 1'b0;
    edge_num = 0;
    for (int i = 1; i <= SYNC; i++) begin
      x.e = i;
      x.v = 4'b0000;
      sb.push_back(x);
    end
  endtask

  task automatic model_push(input logic r);
    logic all1, all0, nl;
    exp_t x;
    win.push_back(r);
    if (win.size() > DEB) void'(win.pop_front());
    all1 = 1'b1;
    all0 = 1'b1;
    foreach (win[i]) begin
      if (win[i] !== 1'b1) all1 = 1'b0;
      if (win[i] !== 1'b0) all0 = 1'b0;
    end
    nl  = all1 ? 1'b1 : (all0 ? 1'b0 : m_level);
    x.e = edge_num + 1 + SYNC;
    x.v = {nl, ~m_level & nl, m_level & ~nl, r ^ nl};
    m_level = nl;
    sb.push_back(x);
  endtask

  // Called at a falling edge: drive, clock once, then compare at the next falling edge.
  task automatic tick(input logic r);
    exp_t x;
    raw_in = r;
    model_push(r);
    @(posedge clk);
    edge_num++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].e < edge_num) void'(sb.pop_front());
    if (sb.size() > 0 && sb[0].e == edge_num) begin
      x = sb.pop_front();
      chk($sformatf("sb_e%0d", edge_num), 8'({level_out, rise_pulse, fall_pulse, busy}), 8'(x.v));
    end
    rise_cnt += int'(rise_pulse);
    fall_cnt += int'(fall_pulse);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    seg_t tbl[13];
    int   r2c, b2c, l2c;
    tbl[0]  = '{1'b0, 20, 0, 1, 1'b0};
    tbl[1]  = '{1'b1, 10, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 20, 0, 0, 1'b0};
    tbl[3]  = '{1'b1,  3, 0, 0, 1'b0};
    tbl[4]  = '{1'b0,  3, 0, 0, 1'b0};
    tbl[5]  = '{1'b1,  3, 0, 0, 1'b0};
    tbl[6]  = '{1'b0,  3, 0, 0, 1'b0};
    tbl[7]  = '{1'b1,  3, 0, 0, 1'b0};
    tbl[8]  = '{1'b0,  3, 0, 0, 1'b0};
    tbl[9]  = '{1'b1, 25, 1, 0, 1'b1};
    tbl[10] = '{1'b0, 15, 0, 0, 1'b1};
    tbl[11] = '{1'b1, 20, 0, 0, 1'b1};
    tbl[12] = '{1'b0, 16, 0, 0, 1'b1};

    // Reset held with raw high: all outputs low without waiting for release.
    reset  = 1'b0;
    raw_in = 1'b1;
    raw2   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outs", 8'({level_out, rise_pulse, fall_pulse, busy}), 8'h0);
    chk("rst_outs2", 8'({level2, rise2, fall2, busy2}), 8'h0);

    // Release with raw held high: busy from edge 3, rise at edge 18 only.
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1);
      if (e == 2)  chk("t1_busy_e2", 8'(busy), 8'h0);
      if (e == 3)  chk("t1_busy_e3", 8'(busy), 8'h1);
      if (e == 17) chk("t1_level_e17", 8'(level_out), 8'h0);
      if (e == 18) chk("t1_level_rise_e18", 8'({level_out, rise_pulse}), 8'h3);
      if (e == 19) chk("t1_rise_e19", 8'(rise_pulse), 8'h0);
    end

    // Segment table: pulse counts and settled level per segment.
    for (int s = 0; s < 13; s++) begin
      rise_cnt = 0;
      fall_cnt = 0;
      for (int k = 0; k < tbl[s].len; k++) tick(tbl[s].val);
      chk($sformatf("seg%0d_rise", s), 8'(rise_cnt), 8'(tbl[s].er));
      chk($sformatf("seg%0d_fall", s), 8'(fall_cnt), 8'(tbl[s].ef));
      chk($sformatf("seg%0d_level", s), 8'(level_out), 8'(tbl[s].el));
    end
    rise_cnt = 0;
    fall_cnt = 0;
    for (int k = 0; k < 20; k++) tick(1'b1);
    chk("seg_dtail_rise", 8'(rise_cnt), 8'h1);
    chk("seg_dtail_fall", 8'(fall_cnt), 8'h1);
    rise_cnt = 0;
    fall_cnt = 0;
    for (int k = 0; k < 20; k++) tick(1'b0);
    chk("seg_end_fall", 8'(fall_cnt), 8'h1);
    chk("seg_end_level", 8'(level_out), 8'h0);

    // Reset mid-wait at cnt=9: outputs clear before the next edge.
    for (int k = 0; k < 11; k++) tick(1'b1);
    chk("t5_busy_pre", 8'({level_out, busy}), 8'h1);
    reset = 1'b0;
    #1;
    chk("t5_async_clear", 8'({level_out, rise_pulse, fall_pulse, busy}), 8'h0);
    @(negedge clk);
    @(negedge clk);
    raw_in = 1'b1;
    model_reset();
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1);
      if (e == 17) chk("t5_level_e17", 8'(level_out), 8'h0);
      if (e == 18) chk("t5_rise_e18", 8'({level_out, rise_pulse}), 8'h3);
    end

    // Reset while high: level drops at once, no fall strobe.
    chk("thr_level_pre", 8'(level_out), 8'h1);
    reset = 1'b0;
    #1;
    chk("thr_async_clear", 8'({level_out, rise_pulse, fall_pulse, busy}), 8'h0);
    @(negedge clk);
    @(negedge clk);

    // Short-chain instance: step reaches level at edge 5, 1-cycle glitch rejected.
    raw_in = 1'b0;
    raw2   = 1'b1;
    model_reset();
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0);
      if (e == 4) chk("t6_e4", 8'({level2, busy2}), 8'h1);
      if (e == 5) chk("t6_e5", 8'({level2, rise2}), 8'h3);
      if (e == 6) chk("t6_rise_e6", 8'(rise2), 8'h0);
    end
    raw2 = 1'b0;
    for (int e = 1; e <= 8; e++) tick(1'b0);
    chk("t6_settle_low", 8'(level2), 8'h0);
    r2c = 0;
    b2c = 0;
    l2c = 0;
    raw2 = 1'b1;
    tick(1'b0);
    raw2 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      r2c += int'(rise2);
      b2c += int'(busy2);
      l2c += int'(level2);
      tick(1'b0);
    end
    chk("t6_glitch_rise", 8'(r2c), 8'h0);
    chk("t6_glitch_level", 8'(l2c), 8'h0);
    chk("t6_glitch_busy", 8'(b2c), 8'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
